gf163_digit_feeder: RTL and testbench
=====================================

Name: gf163_digit_feeder

Overview:
- Operand sequencer that sits directly upstream of the first PE of the 16-bit-digit systolic GF(2^163) multiplier array.
- Captures three 163-bit operands in one handshake:
  - a, multiplicand
  - b, multiplier
  - g, the reduction polynomial without its x^163 term
- Zero-pads each operand to NDIG*DIGITS bits and streams it MSB-digit-first as one 16-bit digit per cycle on the PE a_in/b_in/g_in lanes.
- Generates the PE ctr control bit, then holds the array idle through a drain window before signalling completion.

Parameters:
- M, 163, field degree; operand width in bits.
- DIGITS, 16, digit width; matches the PE lane width.
- NDIG, 11, digits per operand; must equal ceil(M/DIGITS).
- DRAIN_CYC, 22, idle cycles after the last digit, covering PE array latency.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-high reset.
- in_valid  in  1  operand triple on a_op/b_op/g_op is valid.
- in_ready  out  1  feeder can accept an operand triple.
- a_op  in  M  multiplicand a(x).
- b_op  in  M  multiplier b(x).
- g_op  in  M  reduction polynomial f(x)-x^M; 0xC9 for NIST B-163.
- a_dig  out  DIGITS  current a digit to the PE a_in.
- b_dig  out  DIGITS  current b digit to the PE b_in.
- g_dig  out  DIGITS  current g digit to the PE g_in.
- ctr  out  1  PE control: 0 = load new b digit / start operation; 1 = hold.
- dig_valid  out  1  a_dig/b_dig/g_dig carry a real digit this cycle.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse at the end of the drain window.

Behaviour:
- Reset (rstn=1 at an edge) applies from any state, including mid-stream or mid-drain. Required values after reset:
  - FSM in IDLE; counters cleared.
  - a_dig=b_dig=g_dig=0, dig_valid=0, ctr=1, busy=0, done=0, in_ready=0.
  - in_ready goes to 1 on the first cycle after rstn deasserts.
- FSM states: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - An edge with in_valid=1 captures {a_op,b_op,g_op} into 176-bit shift registers (13 zero MSBs of padding each), sets busy=1 and moves to STREAM.
  - in_ready drops to 0 in the same registered update.
- STREAM (dig_cnt runs 0..NDIG-1, one digit per cycle):
  - Outputs are registered: digit k appears exactly one cycle after the edge that captured or shifted it.
  - First STREAM cycle outputs digit 0 = bits [175:160]; upper 13 bits are 0, low 3 bits are operand bits [162:160].
  - Each subsequent cycle shifts all three registers left by DIGITS.
  - dig_valid=1 on every STREAM cycle.
  - ctr=0 only while digit 0 is presented; ctr=1 for digits 1..NDIG-1.
  - After digit NDIG-1 is presented, go to DRAIN.
- DRAIN:
  - Digits are forced to 0; dig_valid=0; ctr=1.
  - drain_cnt counts DRAIN_CYC cycles, then go to DONE.
- DONE: done=1 for exactly one cycle; busy=0 in the next cycle; return to IDLE with in_ready=1.
- Latency and throughput:
  - Capture edge to first digit: 1 cycle.
  - Capture edge to done: 1+NDIG+DRAIN_CYC cycles (34 by default).
  - At most one operation in flight. in_valid while busy is ignored; the operand is not captured and is not queued.
- Counter widths: $clog2(NDIG) and $clog2(DRAIN_CYC+1). No wrap occurs; counters reset to 0 on state entry.
- DRAIN_CYC=0 goes from STREAM directly to DONE.
- All outputs are registered; none depends combinationally on in_valid or operand inputs.

Optional Feature:
- Macro: GF163_FEEDER_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in STREAM or DRAIN: all shift registers, counters and the FSM freeze, and dig_valid=0.
  - ctr and digit outputs hold their last values.
  - done is never asserted during stall; a DONE-state pulse is delayed until stall=0.
  - Reset overrides stall.
- Undefined: no stall port; behaviour as above.

Test Plan:
- Reset mid-STREAM (after digit 4): assert rstn 1 cycle -> next cycle dig_valid=0, busy=0, ctr=1; in_ready=1 one cycle after release.
- a_op=163'h1, b_op=1<<162, g_op=163'hC9, in_valid 1 cycle -> stream digits:
  - a_dig: 0x0000 x10 then 0x0001.
  - b_dig: 0x0004 then 0x0000 x10.
  - g_dig: 0x0000 x10 then 0x00C9.
  - ctr = 0,1,1,...; done exactly 34 cycles after the capture edge.
- a_op=all-ones(163) -> a_dig digit0=0x0007, digits1..10=0xFFFF; pad bits never leak.
- in_valid held high continuously -> exactly one capture per 35-cycle window; the operand presented while busy is not captured and does not reappear.
- Two back-to-back operations -> second first-digit appears 1 cycle after the second capture, with ctr=0 again on that digit.
- With GF163_FEEDER_STALL_EN: stall=1 for 3 cycles at digit 5 -> digit 5 is held, dig_valid=0 for 3 cycles, and done is delayed by exactly 3 cycles (37).

Source files
------------

// File: rtl/gf163_digit_feeder.sv
// Operand sequencer for the 16-bit-digit systolic GF(2^163) multiplier: captures a/b/g,
// streams them MSB-digit-first with the PE ctr bit, then drains. Optional stall port: GF163_FEEDER_STALL_EN.
module gf163_digit_feeder #(
  parameter int unsigned M         = 163,
  parameter int unsigned DIGITS    = 16,
  parameter int unsigned NDIG      = 11,
  parameter int unsigned DRAIN_CYC = 22
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
`ifdef GF163_FEEDER_STALL_EN
  input  logic              stall,
`endif
  output logic              in_ready,
  input  logic [M-1:0]      a_op,
  input  logic [M-1:0]      b_op,
  input  logic [M-1:0]      g_op,
  output logic [DIGITS-1:0] a_dig,
  output logic [DIGITS-1:0] b_dig,
  output logic [DIGITS-1:0] g_dig,
  output logic              ctr,
  output logic              dig_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W  = NDIG * DIGITS;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
  localparam logic [CW-1:0] DIG_LAST   = CW'(NDIG - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     dig_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [W-1:0]      sr_a, sr_b, sr_g;
  logic [W-1:0]      a_pad, b_pad, g_pad;
  logic              stall_i, accept, freeze, last_dig;

  logic              in_ready_d, busy_d, done_d, dig_valid_d, ctr_d;
  logic [DIGITS-1:0] a_d, b_d, g_d;

`ifdef GF163_FEEDER_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign a_pad    = W'(a_op);
  assign b_pad    = W'(b_op);
  assign g_pad    = W'(g_op);
  assign accept   = (state == S_IDLE) && in_ready && in_valid;
  assign freeze   = stall_i && (state != S_IDLE);
  assign last_dig = (dig_cnt == DIG_LAST);

  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_STREAM;
      S_STREAM: if (!freeze && last_dig)
                  state_nxt = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
      S_DRAIN:  if (!freeze && drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      S_DONE:   if (!freeze) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; digit 0 comes straight from the
  // padded operand so it is presented on the cycle after the capture edge.
  always_comb begin
    in_ready_d  = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    dig_valid_d = 1'b0;
    ctr_d       = 1'b1;
    a_d         = '0;
    b_d         = '0;
    g_d         = '0;
    unique case (state)
      S_IDLE: begin
        in_ready_d = !accept;
        if (accept) begin
          busy_d      = 1'b1;
          dig_valid_d = 1'b1;
          ctr_d       = 1'b0;
          a_d         = a_pad[W-1 -: DIGITS];
          b_d         = b_pad[W-1 -: DIGITS];
          g_d         = g_pad[W-1 -: DIGITS];
        end
      end
      S_STREAM, S_DRAIN: begin
        busy_d = 1'b1;
        if (freeze) begin
          ctr_d = ctr;
          a_d   = a_dig;
          b_d   = b_dig;
          g_d   = g_dig;
        end else if (state == S_STREAM && !last_dig) begin
          dig_valid_d = 1'b1;
          a_d         = sr_a[W-1 -: DIGITS];
          b_d         = sr_b[W-1 -: DIGITS];
          g_d         = sr_g[W-1 -: DIGITS];
        end
      end
      S_DONE: begin
        if (!freeze) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Shift registers already hold digit 1 at the top after capture.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sr_a      <= '0;
      sr_b      <= '0;
      sr_g      <= '0;
      dig_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          dig_cnt   <= '0;
          drain_cnt <= '0;
          if (accept) begin
            sr_a <= a_pad << DIGITS;
            sr_b <= b_pad << DIGITS;
            sr_g <= g_pad << DIGITS;
          end
        end
        S_STREAM: begin
          if (!freeze) begin
            if (!last_dig) begin
              sr_a    <= sr_a << DIGITS;
              sr_b    <= sr_b << DIGITS;
              sr_g    <= sr_g << DIGITS;
              dig_cnt <= dig_cnt + 1'b1;
            end else begin
              dig_cnt   <= '0;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: if (!freeze) drain_cnt <= drain_cnt + 1'b1;
        default: begin
          dig_cnt   <= '0;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dig_valid <= 1'b0;
      ctr       <= 1'b1;
      a_dig     <= '0;
      b_dig     <= '0;
      g_dig     <= '0;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      dig_valid <= dig_valid_d;
      ctr       <= ctr_d;
      a_dig     <= a_d;
      b_dig     <= b_d;
      g_dig     <= g_d;
    end
  end

endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Self-checking bench for gf163_digit_feeder: scoreboard of expected digits plus directed timing checks.
module tb_gf163_digit_feeder;

  localparam int M = 163, DIGITS = 16, NDIG = 11, DRAIN_CYC = 22, W = NDIG * DIGITS;

  logic              clk = 1'b0;
  logic              rstn, in_valid, in_ready;
  logic [M-1:0]      a_op, b_op, g_op;
  logic [DIGITS-1:0] a_dig, b_dig, g_dig;
  logic              ctr, dig_valid, busy, done;
`ifdef GF163_FEEDER_STALL_EN
  logic              stall;
`endif

  always #5 clk = ~clk;

  gf163_digit_feeder #(.M(M), .DIGITS(DIGITS), .NDIG(NDIG), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid),
`ifdef GF163_FEEDER_STALL_EN
    .stall(stall),
`endif
    .in_ready(in_ready), .a_op(a_op), .b_op(b_op), .g_op(g_op),
    .a_dig(a_dig), .b_dig(b_dig), .g_dig(g_dig),
    .ctr(ctr), .dig_valid(dig_valid), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic        c;
  } dig_t;

  dig_t        q[$];
  logic [15:0] rx_a[16], rx_b[16], rx_g[16];
  int          rx_n = 0;
  int          vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] rnd();
    logic [191:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[159:0], 32'($urandom)};
    return r[M-1:0];
  endfunction

  task automatic push_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g);
    logic [W-1:0] pa, pb, pg;
    dig_t d;
    pa = W'(a); pb = W'(b); pg = W'(g);
    for (int k = 0; k < NDIG; k++) begin
      d.a = pa[W-1-16*k -: 16];
      d.b = pb[W-1-16*k -: 16];
      d.g = pg[W-1-16*k -: 16];
      d.c = (k != 0);
      q.push_back(d);
    end
  endtask

  // Digit monitor: every valid digit must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    dig_t e;
    if (dig_valid === 1'b1) begin
      if (q.size() == 0) check("unexpected_digit", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("digit", {15'd0, a_dig, b_dig, g_dig, ctr}, {15'd0, e});
      end
      if (rx_n < 16) begin
        rx_a[rx_n] = a_dig; rx_b[rx_n] = b_dig; rx_g[rx_n] = g_dig;
      end
      rx_n++;
    end
  end

  // Waits for in_ready, presents the triple and returns just after the capture edge.
  task automatic start_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g,
                          input bit hold_valid);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
    end
    if (i == 100) check("in_ready_timeout", 64'd0, 64'd1);
    a_op = a; b_op = b; g_op = g; in_valid = 1'b1;
    push_op(a, b, g);
    rx_n = 0;
    @(posedge clk); #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic [M-1:0] g,
                        input int stall_at, output int done_cyc);
    logic [W-1:0] pa;
    pa = W'(a);
    start_op(a, b, g, 1'b0);
    done_cyc = -1;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
`ifdef GF163_FEEDER_STALL_EN
      if (stall_at >= 0) begin
        if (c > stall_at && c <= stall_at + 3) begin
          check("stall_valid", {63'd0, dig_valid}, 64'd0);
          check("stall_hold_a", {48'd0, a_dig}, {48'd0, pa[W-1-16*stall_at -: 16]});
          check("stall_no_done", {63'd0, done}, 64'd0);
        end
        if (c == stall_at) stall = 1'b1;
        if (c == stall_at + 3) stall = 1'b0;
      end
`endif
      if (done === 1'b1) begin
        done_cyc = c;
        check("busy_at_done", {63'd0, busy}, 64'd0);
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("ready_after_done", {63'd0, in_ready}, 64'd1);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [M-1:0] ones, bv, x3;
    int dc, starts, first_start, first_done;
    ones = '1;
    bv = '0; bv[162] = 1'b1;
    rstn = 1'b1; in_valid = 1'b0; a_op = '0; b_op = '0; g_op = '0;
`ifdef GF163_FEEDER_STALL_EN
    stall = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_dig_valid", {63'd0, dig_valid}, 64'd0);
    check("rst_ctr", {63'd0, ctr}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_digits", {16'd0, a_dig, b_dig, g_dig}, 64'd0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", {63'd0, in_ready}, 64'd1);

    // Directed single-bit operands
    run_op(163'h1, bv, 163'hC9, -1, dc);
    check("latency_basic", 64'(dc), 64'd34);
    check("basic_count", 64'(rx_n), 64'd11);
    check("basic_a0", {48'd0, rx_a[0]}, 64'h0000);
    check("basic_a10", {48'd0, rx_a[10]}, 64'h0001);
    check("basic_b0", {48'd0, rx_b[0]}, 64'h0004);
    check("basic_b1", {48'd0, rx_b[1]}, 64'h0000);
    check("basic_g9", {48'd0, rx_g[9]}, 64'h0000);
    check("basic_g10", {48'd0, rx_g[10]}, 64'h00C9);

    // All-ones multiplicand: pad bits must stay zero
    run_op(ones, rnd(), rnd(), -1, dc);
    check("latency_ones", 64'(dc), 64'd34);
    check("ones_a0", {48'd0, rx_a[0]}, 64'h0007);
    check("ones_a5", {48'd0, rx_a[5]}, 64'hFFFF);
    check("ones_a10", {48'd0, rx_a[10]}, 64'hFFFF);

    // Two operations back to back
    run_op(rnd(), rnd(), rnd(), -1, dc);
    check("latency_b2b_1", 64'(dc), 64'd34);
    run_op(rnd(), rnd(), rnd(), -1, dc);
    check("latency_b2b_2", 64'(dc), 64'd34);

    // Reset mid-stream after digit 4
    start_op(rnd(), rnd(), rnd(), 1'b0);
    repeat (4) @(posedge clk); #1;
    check("mid_digit_index", 64'(rx_n), 64'd4);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", {63'd0, dig_valid}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ctr", {63'd0, ctr}, 64'd1);
    check("mid_rst_ready", {63'd0, in_ready}, 64'd0);
    q.delete();
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_ready_release", {63'd0, in_ready}, 64'd1);

    // in_valid held high: busy-time operands ignored, one capture per 35 cycles
    start_op(rnd(), rnd(), rnd(), 1'b1);
    a_op = rnd(); b_op = rnd(); g_op = rnd();
    starts = 0; first_start = -1; first_done = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 20) begin
        x3 = rnd();
        a_op = x3; b_op = ~x3; g_op = 163'hC9;
        push_op(x3, ~x3, 163'hC9);
      end
      if (done === 1'b1 && first_done < 0) first_done = c;
      if (dig_valid === 1'b1 && ctr === 1'b0) begin
        starts++;
        if (first_start < 0) first_start = c;
      end
    end
    in_valid = 1'b0;
    check("held_done", 64'(first_done), 64'd34);
    check("held_second_start", 64'(first_start), 64'd35);
    check("held_starts", 64'(starts), 64'd1);
    dc = -1;
    for (int c = 41; c <= 120; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin dc = c; break; end
    end
    check("held_second_done", 64'(dc), 64'd69);
    @(posedge clk); #1;
    check("held_scoreboard", 64'(q.size()), 64'd0);

`ifdef GF163_FEEDER_STALL_EN
    run_op(rnd(), rnd(), rnd(), 5, dc);
    check("latency_stall", 64'(dc), 64'd37);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
